// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 10;
  localparam int FETCH_INSTR_W = 32;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear and occupancy count.
// The head is read straight from the storage flops, so it has no path from the inputs.
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  T                         data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output T                         head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T               mem_q [DEPTH];
  logic [AW-1:0]  wr_q;
  logic [AW-1:0]  rd_q;
  logic [CW-1:0]  cnt_q;
  logic           push_en;
  logic           pop_en;

  assign pop_en  = pop_i && (cnt_q != '0);
  assign push_en = push_i && ((cnt_q != CW'(DEPTH)) || pop_en);

  // Clear drops the pointers only; stale storage is hidden by the zero count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_en) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_en) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_en) - CW'(pop_en);
    end
  end

  assign valid_o = (cnt_q != '0);
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited in-order imem requests, instruction FIFO, redirect/flush.
// Define FETCH_PERF_EN to add the perf_redirects / perf_bubbles saturating counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = FETCH_ADDR_W,
  parameter int                INSTR_W  = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               branch,
  input  logic [ADDR_W-1:0]  target_address,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               flush
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        perf_redirects,
  output logic [15:0]        perf_bubbles
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic              flush_q;
  logic [CW-1:0]     out_cnt;
  logic [CW-1:0]     fifo_cnt;
  logic [CW:0]       credit_used;
  logic              req_fire;
  logic              rsp_pop;
  logic              rsp_keep;
  logic              deq;
  logic              tag_valid;
  logic [ADDR_W-1:0] tag_head;
  fetch_entry_t      push_entry;
  fetch_entry_t      head_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Credit uses registered counts only, so a pop at full frees a slot one cycle later.
  always_comb begin
    credit_used    = {1'b0, out_cnt} + {1'b0, fifo_cnt};
    imem_req_valid = (state_q == RUN) && (credit_used < (CW+1)'(DEPTH));
  end

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_pop  = imem_rsp_valid && tag_valid;
  assign rsp_keep = rsp_pop && !branch && (drop_q == '0);
  assign deq      = instr_valid && instr_ready;

  // On redirect everything still in flight after this cycle becomes stale.
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (branch)        pc_d = target_address;
    else if (req_fire) pc_d = pc_q + 1'b1;
    if (branch)
      drop_d = out_cnt + CW'(req_fire) - CW'(rsp_pop);
    else if (rsp_pop && (drop_q != '0))
      drop_d = drop_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      drop_q  <= '0;
      flush_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      flush_q <= branch;
    end
  end

  // The tag queue occupancy is the outstanding-request count.
  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (logic [ADDR_W-1:0])
  ) u_tag_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (1'b0),
    .push_i  (req_fire),
    .data_i  (pc_q),
    .pop_i   (rsp_pop),
    .valid_o (tag_valid),
    .head_o  (tag_head),
    .count_o (out_cnt)
  );

  assign push_entry = '{pc: tag_head, instr: imem_rsp_data};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .T     (fetch_entry_t)
  ) u_instr_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (branch),
    .push_i  (rsp_keep),
    .data_i  (push_entry),
    .pop_i   (deq),
    .valid_o (instr_valid),
    .head_o  (head_entry),
    .count_o (fifo_cnt)
  );

  assign imem_req_addr = pc_q;
  assign instr_data    = head_entry.instr;
  assign instr_pc      = head_entry.pc;
  assign flush         = flush_q;

`ifdef FETCH_PERF_EN
  logic [15:0] redir_q;
  logic [15:0] bubble_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redir_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (branch && (redir_q != '1)) redir_q <= redir_q + 1'b1;
      if (instr_ready && !instr_valid && (bubble_q != '1)) bubble_q <= bubble_q + 1'b1;
    end
  end

  assign perf_redirects = redir_q;
  assign perf_bubbles   = bubble_q;
`endif

endmodule
